axis_vec_serializer: RTL
========================

// Module: axis_vec_serializer
// PURPOSE
//  Width-down converter on the output side of the matrix-vector multiplier.
//  - Accepts one wide AXI-Stream beat carrying an R-element result vector y.
//  - Emits R narrow beats, one sign-extended element per beat, element 0 first.
//  - Asserts tlast on the final beat, so a narrow stream consumer (DMA, FIFO, UART bridge)
//    can read results.
//  - Sustains full narrow-side throughput: no bubble between consecutive vectors.
// PARAMETERS
//  R      8        number of elements per input vector (R >= 1)
//  W_Y    19       width of one element in the input bus, two's complement
//  W_OUT  32       output element width; must be >= W_Y (elaborate-time $fatal otherwise)
// PORTS
//  clk               in   1        clock, all logic on rising edge
//  rstn              in   1        synchronous reset, active low
//  s_axis_y_tready   out  1        slave ready
//  s_axis_y_tvalid   in   1        slave valid
//  s_axis_y_tdata    in   R*W_Y    packed vector; element r at bits [r*W_Y +: W_Y]
//  m_axis_tready     in   1        master ready
//  m_axis_tvalid     out  1        master valid
//  m_axis_tdata      out  W_OUT    current element, sign-extended
//  m_axis_tlast      out  1        high on the beat carrying element R-1
// BEHAVIOUR
//  - State: buf (R*W_Y register), busy flag, idx counter ($clog2(R), min 1 bit).
//    - EMPTY (busy=0): no vector held.
//    - SEND (busy=1): element buf[idx] presented.
//  - Reset (rstn=0 at clk edge): busy=0, idx=0, buf=0.
//    - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_y_tready=1.
//    - Reset mid-packet drops the remaining elements; nothing is replayed.
//  - Handshakes:
//    - Slave handshake: s_fire = s_axis_y_tvalid & s_axis_y_tready.
//    - Master handshake: m_fire = m_axis_tvalid & m_axis_tready.
//  - s_axis_y_tready = ~busy | (m_axis_tready & idx==R-1).
//    - Combinational path from m_axis_tready to s_axis_y_tready is permitted.
//  - m_axis_tvalid = busy.
//  - m_axis_tdata = {{(W_OUT-W_Y){buf[idx][W_Y-1]}}, buf[idx]}.
//  - m_axis_tlast = busy & (idx==R-1).
//  - Transitions (per clk edge):
//    - EMPTY & s_fire -> SEND; buf<=tdata, idx<=0.
//    - SEND & m_fire & idx<R-1 -> idx<=idx+1.
//    - SEND & m_fire & idx==R-1 & ~s_fire -> EMPTY; idx<=0.
//    - SEND & m_fire & idx==R-1 & s_fire -> SEND; buf<=new tdata, idx<=0 (zero-bubble).
//    - SEND & ~m_fire -> hold all state.
//  - Output stability: while m_axis_tvalid & ~m_axis_tready, tdata and tlast hold.
//    tvalid never drops without a handshake, except on reset.
//  - Latency: wide beat accepted at edge N -> element 0 valid after edge N.
//    Packet is exactly R beats.
//  - R=1: every beat has tlast=1; block acts as a 1-deep register slice with sign extension.
//  - No arithmetic beyond sign extension; input bits pass through unmodified.
// TESTING
//  - Single vector: R=8, W_Y=19, W_OUT=32, y={7,6,...,0}, tready=1.
//    -> 8 beats 0..7 on consecutive cycles, tlast only on value 7.
//  - Sign extension: element0=19'h7FFFF (-1), element1=19'h40000 (-262144).
//    -> tdata 32'hFFFFFFFF, then 32'hFFFC0000.
//  - Back-to-back: 3 vectors offered continuously, tready=1.
//    -> 24 beats in 24 consecutive cycles; s_axis_y_tready pulses high on each tlast cycle.
//  - Backpressure: m_axis_tready low for 5 cycles at idx=3.
//    -> tdata and tvalid held, idx stays 3; s_axis_y_tready=0 throughout.
//  - Reset mid-packet: rstn=0 for 1 cycle after beat 4.
//    -> tvalid=0 next cycle, s_axis_y_tready=1.
//    -> The next vector starts cleanly at element 0.
//  - Random: 500 vectors, 10% valid/ready probability.
//    -> Scoreboard matches every element and tlast position.

Source files
------------

// File: rtl/axis_vec_serializer.sv
// Width-down converter: one wide R-element vector beat in, R narrow sign-extended beats out, element 0 first.
// Latency: element 0 valid the cycle after the wide beat is accepted; the next vector loads on the last beat, so there is no bubble.
module axis_vec_serializer #(
    parameter int R     = 8,
    parameter int W_Y   = 19,
    parameter int W_OUT = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 s_axis_y_tready,
    input  logic                 s_axis_y_tvalid,
    input  logic [R*W_Y-1:0]     s_axis_y_tdata,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tvalid,
    output logic [W_OUT-1:0]     m_axis_tdata,
    output logic                 m_axis_tlast
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);

    generate
        if (W_OUT < W_Y) begin : g_bad_width
            $fatal(1, "axis_vec_serializer: W_OUT (%0d) must be >= W_Y (%0d)", W_OUT, W_Y);
        end
        if (R < 1) begin : g_bad_r
            $fatal(1, "axis_vec_serializer: R (%0d) must be >= 1", R);
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           idx_d;
    logic [R-1:0][W_Y-1:0]   vec_q;
    logic                    vec_load;
    logic                    busy;
    logic                    at_last;
    logic                    s_fire;
    logic                    m_fire;
    logic [W_Y-1:0]          elem;

    assign busy    = (state_q == ST_SEND);
    assign at_last = (idx_q == LAST_IDX);
    assign elem    = vec_q[idx_q];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (vec_load) begin
                vec_q <= s_axis_y_tdata;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        vec_load        = 1'b0;
        // Ready on the last beat lets the next vector load in the same edge.
        s_axis_y_tready = ~busy | (m_axis_tready & at_last);
        m_axis_tvalid   = busy;
        m_axis_tlast    = busy & at_last;
        m_axis_tdata    = W_OUT'($signed(elem));
        s_fire          = s_axis_y_tvalid & s_axis_y_tready;
        m_fire          = m_axis_tvalid & m_axis_tready;

        case (state_q)
            ST_EMPTY: begin
                if (s_fire) begin
                    state_d  = ST_SEND;
                    idx_d    = '0;
                    vec_load = 1'b1;
                end
            end
            ST_SEND: begin
                if (m_fire) begin
                    if (!at_last) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        idx_d = '0;
                        if (s_fire) begin
                            vec_load = 1'b1;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end
        endcase
    end

endmodule
